// File: rtl/float_mult_result_fifo.sv
// Result buffer for a float multiplier: FIFO of {product, flags} with sticky flag accumulation.
// Optional FLOAT_MULT_SAT_EN stores overflow/underflow results as saturated max-finite / signed zero.
module float_mult_result_fifo #(
   parameter int FLOAT_SIZE    = 32,
   parameter int EXPONENT_SIZE = 8,
   parameter int MANTISSA_SIZE = 23,
   parameter int DEPTH         = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [FLOAT_SIZE-1:0]      in_data,
   input  logic                       in_overflow,
   input  logic                       in_underflow,
   input  logic                       in_inexact,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [FLOAT_SIZE-1:0]      out_data,
   output logic [2:0]                 out_flags,
   output logic [2:0]                 sticky_flags,
   input  logic                       clear_sticky,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [FLOAT_SIZE-1:0] data_mem_q [DEPTH];
   logic [2:0]            flags_mem_q [DEPTH];

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [2:0]            sticky_q, sticky_d;

   logic                  push;
   logic                  pop;
   logic [2:0]            in_flags;
   logic                  in_sign;
   logic [EXPONENT_SIZE-1:0] in_exp;
   logic [MANTISSA_SIZE-1:0] in_mant;
   logic [FLOAT_SIZE-1:0] wr_data_d;

   // Readiness comes from registered occupancy only, so out_ready never feeds in_ready.
   assign in_ready  = (count_q != CNT_W'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign in_flags  = {in_overflow, in_underflow, in_inexact};

   assign in_sign = in_data[FLOAT_SIZE-1];
   assign in_exp  = in_data[MANTISSA_SIZE +: EXPONENT_SIZE];
   assign in_mant = in_data[MANTISSA_SIZE-1:0];

   always_comb begin
      wr_data_d = {in_sign, in_exp, in_mant};
`ifdef FLOAT_MULT_SAT_EN
      if (in_overflow) begin
         wr_data_d = {in_sign, {(EXPONENT_SIZE-1){1'b1}}, 1'b0, {MANTISSA_SIZE{1'b1}}};
      end else if (in_underflow) begin
         wr_data_d = {in_sign, {(FLOAT_SIZE-1){1'b0}}};
      end
`endif
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // A clear coinciding with a push leaves exactly that push's flags.
   always_comb begin
      sticky_d = sticky_q;
      if (clear_sticky) sticky_d = 3'b000;
      if (push)         sticky_d = sticky_d | in_flags;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         sticky_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         sticky_q <= sticky_d;
      end
   end

   // Storage needs no reset: occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem_q[wr_ptr_q]  <= wr_data_d;
         flags_mem_q[wr_ptr_q] <= in_flags;
      end
   end

   assign out_data     = out_valid ? data_mem_q[rd_ptr_q]  : '0;
   assign out_flags    = out_valid ? flags_mem_q[rd_ptr_q] : 3'b000;
   assign sticky_flags = sticky_q;
   assign count        = count_q;

endmodule

// File: tb/tb_float_mult_result_fifo.sv
// Directed bench for float_mult_result_fifo; expected values are hand-computed constants and a queue.
module tb_float_mult_result_fifo;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_overflow, in_underflow, in_inexact;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [2:0]  out_flags;
   logic [2:0]  sticky_flags;
   logic        clear_sticky;
   logic [2:0]  count;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

`ifdef FLOAT_MULT_SAT_EN
   localparam logic [31:0] EXP_OVF = 32'h7F7FFFFF;
   localparam logic [31:0] EXP_UNF = 32'h80000000;
`else
   localparam logic [31:0] EXP_OVF = 32'h7F800000;
   localparam logic [31:0] EXP_UNF = 32'h80000123;
`endif

   float_mult_result_fifo #(
      .FLOAT_SIZE(32), .EXPONENT_SIZE(8), .MANTISSA_SIZE(23), .DEPTH(4)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_overflow(in_overflow), .in_underflow(in_underflow), .in_inexact(in_inexact),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_flags(out_flags), .sticky_flags(sticky_flags),
      .clear_sticky(clear_sticky), .count(count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clear_sticky = 1'b0;
      in_overflow = 1'b0; in_underflow = 1'b0; in_inexact = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
      n_checks++; if (out_flags !== 3'b000) begin n_fail++; $display("FAIL reset_out_flags got %b want 000", out_flags); end
      n_checks++; if (sticky_flags !== 3'b000) begin n_fail++; $display("FAIL reset_sticky got %b want 000", sticky_flags); end
   endtask

   task automatic test_first_push();
      in_valid = 1'b1; in_data = 32'h40400000;
      step();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_out_valid got %b want 1", out_valid); end
      n_checks++; if (out_data !== 32'h40400000) begin n_fail++; $display("FAIL first_out_data got %h want 40400000", out_data); end
      n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL first_count got %0d want 1", count); end
      n_checks++; if (sticky_flags !== 3'b000) begin n_fail++; $display("FAIL first_sticky got %b want 000", sticky_flags); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL first_pop_count got %0d want 0", count); end
      n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL first_pop_data got %h want 0", out_data); end
      // out_ready on an empty FIFO must do nothing
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL empty_pop_count got %0d want 0", count); end
   endtask

   task automatic test_full();
      logic [31:0] vals [4];
      vals[0] = 32'h3F800000; vals[1] = 32'h40000000; vals[2] = 32'hC0A00000; vals[3] = 32'h41200000;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = vals[i];
         exp_q.push_back(vals[i]);
         step();
      end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b want 0", in_ready); end
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d want 4", count); end
      in_data = 32'hDEADBEEF;
      step();
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_reject_count got %0d want 4", count); end
      out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_with_pop got %b want 0", in_ready); end
      for (int i = 0; i < 4; i++) begin
         logic [31:0] e;
         e = exp_q.pop_front();
         n_checks++; if (out_data !== e) begin n_fail++; $display("FAIL full_drain_%0d got %h want %h", i, out_data, e); end
         step();
         in_valid = 1'b0;
      end
      out_ready = 1'b0;
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL full_drain_count got %0d want 0", count); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_drain_valid got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_data = 32'h42000000 + i;
         exp_q.push_back(in_data);
         step();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         logic [31:0] e;
         in_data = 32'h43000000 + i;
         e = exp_q.pop_front();
         exp_q.push_back(in_data);
         n_checks++; if (out_data !== e) begin n_fail++; $display("FAIL b2b_data_%0d got %h want %h", i, out_data, e); end
         step();
         n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count_%0d got %0d want 2", i, count); end
      end
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         logic [31:0] e;
         e = exp_q.pop_front();
         n_checks++; if (out_data !== e) begin n_fail++; $display("FAIL b2b_drain_%0d got %h want %h", i, out_data, e); end
         step();
      end
      out_ready = 1'b0;
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL b2b_final_count got %0d want 0", count); end
   endtask

   task automatic test_overflow();
      clear_sticky = 1'b1;
      step();
      clear_sticky = 1'b0;
      in_valid = 1'b1; in_data = 32'h7F800000; in_overflow = 1'b1;
      step();
      in_valid = 1'b0; in_overflow = 1'b0;
      n_checks++; if (out_data !== EXP_OVF) begin n_fail++; $display("FAIL ovf_data got %h want %h", out_data, EXP_OVF); end
      n_checks++; if (out_flags !== 3'b100) begin n_fail++; $display("FAIL ovf_flags got %b want 100", out_flags); end
      n_checks++; if (sticky_flags !== 3'b100) begin n_fail++; $display("FAIL ovf_sticky got %b want 100", sticky_flags); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h80000123; in_underflow = 1'b1;
      step();
      in_valid = 1'b0; in_underflow = 1'b0;
      n_checks++; if (out_data !== EXP_UNF) begin n_fail++; $display("FAIL unf_data got %h want %h", out_data, EXP_UNF); end
      n_checks++; if (out_flags !== 3'b010) begin n_fail++; $display("FAIL unf_flags got %b want 010", out_flags); end
      n_checks++; if (sticky_flags !== 3'b110) begin n_fail++; $display("FAIL unf_sticky got %b want 110", sticky_flags); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_clear_sticky();
      in_valid = 1'b1; in_data = 32'h3F800001; in_inexact = 1'b1; clear_sticky = 1'b1;
      step();
      in_valid = 1'b0; in_inexact = 1'b0; clear_sticky = 1'b0;
      n_checks++; if (sticky_flags !== 3'b001) begin n_fail++; $display("FAIL clr_push_sticky got %b want 001", sticky_flags); end
      n_checks++; if (out_flags !== 3'b001) begin n_fail++; $display("FAIL clr_push_flags got %b want 001", out_flags); end
      n_checks++; if (out_data !== 32'h3F800001) begin n_fail++; $display("FAIL clr_push_data got %h want 3f800001", out_data); end
      clear_sticky = 1'b1; out_ready = 1'b1;
      step();
      clear_sticky = 1'b0; out_ready = 1'b0;
      n_checks++; if (sticky_flags !== 3'b000) begin n_fail++; $display("FAIL clr_only_sticky got %b want 000", sticky_flags); end
   endtask

   task automatic test_reset_midstream();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 32'h44000000 + i; in_inexact = 1'b1;
         step();
      end
      n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL mid_pre_count got %0d want 3", count); end
      reset = 1'b1; out_ready = 1'b1; clear_sticky = 1'b1; in_overflow = 1'b1;
      step();
      reset = 1'b0; out_ready = 1'b0; clear_sticky = 1'b0; in_valid = 1'b0;
      in_overflow = 1'b0; in_inexact = 1'b0;
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL mid_count got %0d want 0", count); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
      n_checks++; if (sticky_flags !== 3'b000) begin n_fail++; $display("FAIL mid_sticky got %b want 000", sticky_flags); end
      n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL mid_out_data got %h want 0", out_data); end
      in_valid = 1'b1; in_data = 32'h45000000;
      step();
      in_valid = 1'b0;
      n_checks++; if (out_data !== 32'h45000000) begin n_fail++; $display("FAIL mid_repush_data got %h want 45000000", out_data); end
      n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL mid_repush_count got %0d want 1", count); end
   endtask

   initial begin
      test_reset();
      test_first_push();
      test_full();
      test_back_to_back();
      test_overflow();
      test_clear_sticky();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/float_mult_result_fifo.md
FLOAT_MULT_RESULT_FIFO -- requirements
Module: float_mult_result_fifo

Interface
Parameters:
REQ-001: FLOAT_SIZE, default 32, total float bit-length.
REQ-002: EXPONENT_SIZE, default 8, exponent field bit-length.
REQ-003: MANTISSA_SIZE, default 23, mantissa field bit-length.
REQ-004: DEPTH, default 4, entry count; power of two, >= 2.
Ports:
REQ-005: clk  input  1  single clock, all state updates on rising edge.
REQ-006: reset  input  1  synchronous, active-high reset.
REQ-007: in_valid  input  1  multiplier result present.
REQ-008: in_ready  output  1  entry free, result accepted this cycle.
REQ-009: in_data  input  FLOAT_SIZE  multiplier product {sign, exponent, mantissa}.
REQ-010: in_overflow, in_underflow, in_inexact  input  1 each  multiplier status flags.
REQ-011: out_valid  output  1  head entry present.
REQ-012: out_ready  input  1  consumer takes head entry.
REQ-013: out_data  output  FLOAT_SIZE  head result.
REQ-014: out_flags  output  3  head flags {overflow, underflow, inexact}.
REQ-015: sticky_flags  output  3  accumulated flags {overflow, underflow, inexact}.
REQ-016: clear_sticky  input  1  clears sticky_flags.
REQ-017: count  output  $clog2(DEPTH)+1  number of stored entries.

Function
REQ-018: The block SHALL buffer multiplier results in FIFO order, accepting a push when in_valid && in_ready.
REQ-019: in_ready SHALL equal (count != DEPTH), derived from registered state only, with no combinational path from out_ready.
REQ-020: A pop SHALL occur when out_valid && out_ready; out_valid SHALL equal (count != 0).
REQ-021: Latency SHALL be one cycle: a result pushed in cycle N is visible on out_data/out_valid in cycle N+1 when the FIFO was empty.
REQ-022: out_data and out_flags SHALL be driven to 0 whenever out_valid is 0.
REQ-023: Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and preserve order.
REQ-024: When full, in_ready SHALL be 0 even if out_ready is 1 that cycle; when empty, out_ready SHALL have no effect.
REQ-025: Read and write pointers SHALL wrap modulo DEPTH without bubbles.
REQ-026: On every push, sticky_flags SHALL become sticky_flags | {in_overflow, in_underflow, in_inexact} in the next cycle.
REQ-027: clear_sticky SHALL zero sticky_flags in the next cycle; with a simultaneous push, sticky_flags SHALL equal that push's flags only.
REQ-028: Flags SHALL be stored per entry and returned unchanged on out_flags with their result.

Reset
REQ-029: With reset high at a clock edge, count, both pointers and sticky_flags SHALL be 0; out_valid 0, in_ready 1, out_data 0, out_flags 0 from the next cycle.
REQ-030: Reset SHALL override simultaneous push, pop and clear_sticky; stored contents are discarded, including entries in flight.

Configuration
REQ-031: Macro FLOAT_MULT_SAT_EN: when defined, a pushed result with in_overflow=1 SHALL be stored as {sign, exponent all-ones minus 1, mantissa all-ones}, and one with in_underflow=1 and in_overflow=0 SHALL be stored as {sign, all zeros}; flags SHALL be stored unmodified.
REQ-032: Without FLOAT_MULT_SAT_EN, in_data SHALL be stored verbatim regardless of flags.

Verification
REQ-033: Reset, then push 0x40400000 flags 000 with out_ready=0 -> next cycle out_valid=1, out_data=0x40400000, count=1, sticky=000.
REQ-034: Push 4 results with out_ready=0 -> in_ready=0 after fourth; a fifth in_valid is not accepted; then pop all -> values returned in order, count returns to 0.
REQ-035: Count=2, push and pop same cycle over 8 cycles -> count stays 2, pointers wrap, order preserved.
REQ-036: Push 0x7F800000 with in_overflow=1 -> with FLOAT_MULT_SAT_EN out_data=0x7F7FFFFF, without it 0x7F800000; out_flags=100, sticky=100.
REQ-037: Push with in_inexact=1 while clear_sticky=1 and sticky=110 -> sticky=001 next cycle.
REQ-038: Reset asserted with count=3 and push pending -> next cycle count=0, out_valid=0, in_ready=1, sticky=000.
